// File: rtl/literal_exec_unit.sv
// Literal-ALU / control-flow execution stage for a midrange 14-bit ISA core.
// Three-cycle latch/decode/execute pipeline owning W, Z/DC/C and a circular return stack.
module literal_exec_unit #(
   parameter int STACK_DEPTH = 8,
   parameter int PC_W        = 11
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [13:0]     ir_in,
   input  logic            ir_valid,
   input  logic [PC_W-1:0] pc_current,
   output logic            busy,
   output logic [7:0]      w_out,
   output logic            status_z,
   output logic            status_dc,
   output logic            status_c,
   output logic            pc_load,
   output logic [PC_W-1:0] pc_target,
   output logic            illegal_op,
   output logic            stack_overflow,
   output logic            stack_underflow,
   output logic            ir_dropped
);

   localparam int SP_W = $clog2(STACK_DEPTH);
   localparam int DW   = SP_W + 1;
   localparam logic [SP_W-1:0] SP_ONE     = SP_W'(1);
   localparam logic [DW-1:0]   DEPTH_ONE  = DW'(1);
   localparam logic [DW-1:0]   DEPTH_FULL = DW'(STACK_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DECODE,
      S_EXEC
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP,
      OP_MOVLW,
      OP_RETLW,
      OP_IORLW,
      OP_ANDLW,
      OP_XORLW,
      OP_SUBLW,
      OP_ADDLW,
      OP_CALL,
      OP_GOTO,
      OP_RETURN,
      OP_CLRW,
      OP_ILLEGAL
   } op_t;

   state_t            state_q, state_d;
   op_t               op_q, op_d;
   logic [13:0]       ir_q, ir_d;
   logic [PC_W-1:0]   retAddr_q, retAddr_d;
   logic [7:0]        w_q, w_d;
   logic              z_q, z_d, dc_q, dc_d, c_q, c_d;
   logic              pcLoad_q, pcLoad_d;
   logic [PC_W-1:0]   pcTarget_q, pcTarget_d;
   logic              illegal_q, illegal_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic [DW-1:0]     depth_q, depth_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              dropped_q, dropped_d;
   logic [PC_W-1:0]   stack_q [STACK_DEPTH];

   logic              pushEn, doPop;
   logic [SP_W-1:0]   spDec;
   logic [7:0]        k8;
   logic [8:0]        addSum;
   logic [4:0]        addNib;
   logic [7:0]        subDiff;

   // Opcode classification; anything not recognised falls through to OP_ILLEGAL.
   function automatic op_t decodeOp(input logic [13:0] ir);
      op_t op;
      op = OP_ILLEGAL;
      case (ir[13:12])
         2'b11: begin
            case (ir[11:10])
               2'b00: op = OP_MOVLW;
               2'b01: op = OP_RETLW;
               2'b10: begin
                  case (ir[9:8])
                     2'b00:   op = OP_IORLW;
                     2'b01:   op = OP_ANDLW;
                     2'b10:   op = OP_XORLW;
                     default: op = OP_ILLEGAL;
                  endcase
               end
               default: op = ir[9] ? OP_ADDLW : OP_SUBLW;
            endcase
         end
         2'b10: op = ir[11] ? OP_GOTO : OP_CALL;
         2'b00: begin
            if (ir == 14'h0008)
               op = OP_RETURN;
            else if (ir[13:7] == 7'b0000010)
               op = OP_CLRW;
            else if (ir[13:7] == 7'b0000000 && ir[4:0] == 5'b00000)
               op = OP_NOP;
            else
               op = OP_ILLEGAL;
         end
         default: op = OP_ILLEGAL;
      endcase
      return op;
   endfunction

   assign k8      = ir_q[7:0];
   assign addSum  = {1'b0, w_q} + {1'b0, k8};
   assign addNib  = {1'b0, w_q[3:0]} + {1'b0, k8[3:0]};
   assign subDiff = k8 - w_q;
   assign spDec   = sp_q - SP_ONE;

   // Next-state logic: latch on ir_valid, classify, then commit everything in S_EXEC.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      ir_d        = ir_q;
      retAddr_d   = retAddr_q;
      w_d         = w_q;
      z_d         = z_q;
      dc_d        = dc_q;
      c_d         = c_q;
      pcLoad_d    = 1'b0;
      pcTarget_d  = pcTarget_q;
      illegal_d   = 1'b0;
      sp_d        = sp_q;
      depth_d     = depth_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      dropped_d   = dropped_q;
      pushEn      = 1'b0;
      doPop       = 1'b0;

      if (ir_valid && state_q != S_IDLE)
         dropped_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (ir_valid) begin
               ir_d      = ir_in;
               retAddr_d = pc_current;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            op_d    = decodeOp(ir_q);
            state_d = S_EXEC;
         end
         S_EXEC: begin
            state_d = S_IDLE;
            case (op_q)
               OP_MOVLW: w_d = k8;
               OP_RETLW: begin
                  w_d   = k8;
                  doPop = 1'b1;
               end
               OP_IORLW: begin
                  w_d = w_q | k8;
                  z_d = (w_d == 8'h00);
               end
               OP_ANDLW: begin
                  w_d = w_q & k8;
                  z_d = (w_d == 8'h00);
               end
               OP_XORLW: begin
                  w_d = w_q ^ k8;
                  z_d = (w_d == 8'h00);
               end
               OP_SUBLW: begin
                  w_d  = subDiff;
                  c_d  = (k8 >= w_q);
                  dc_d = (k8[3:0] >= w_q[3:0]);
                  z_d  = (subDiff == 8'h00);
               end
               OP_ADDLW: begin
                  w_d  = addSum[7:0];
                  c_d  = addSum[8];
                  dc_d = addNib[4];
                  z_d  = (addSum[7:0] == 8'h00);
               end
               OP_CALL: begin
                  pushEn     = 1'b1;
                  pcTarget_d = PC_W'(ir_q[10:0]);
                  pcLoad_d   = 1'b1;
               end
               OP_GOTO: begin
                  pcTarget_d = PC_W'(ir_q[10:0]);
                  pcLoad_d   = 1'b1;
               end
               OP_RETURN: doPop = 1'b1;
               OP_CLRW: begin
                  w_d = 8'h00;
                  z_d = 1'b1;
               end
               OP_ILLEGAL: illegal_d = 1'b1;
               default: ;
            endcase

            // A full stack keeps its depth; the write at sp lands on the oldest entry.
            if (pushEn) begin
               sp_d = sp_q + SP_ONE;
               if (depth_q == DEPTH_FULL)
                  overflow_d = 1'b1;
               else
                  depth_d = depth_q + DEPTH_ONE;
            end

            if (doPop) begin
               pcLoad_d = 1'b1;
               if (depth_q == '0) begin
                  pcTarget_d  = '0;
                  underflow_d = 1'b1;
               end else begin
                  sp_d       = spDec;
                  depth_d    = depth_q - DEPTH_ONE;
                  pcTarget_d = stack_q[spDec];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // All architectural state moves on the falling clock edge.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         op_q        <= OP_NOP;
         ir_q        <= '0;
         retAddr_q   <= '0;
         w_q         <= '0;
         z_q         <= 1'b0;
         dc_q        <= 1'b0;
         c_q         <= 1'b0;
         pcLoad_q    <= 1'b0;
         pcTarget_q  <= '0;
         illegal_q   <= 1'b0;
         sp_q        <= '0;
         depth_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         dropped_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         ir_q        <= ir_d;
         retAddr_q   <= retAddr_d;
         w_q         <= w_d;
         z_q         <= z_d;
         dc_q        <= dc_d;
         c_q         <= c_d;
         pcLoad_q    <= pcLoad_d;
         pcTarget_q  <= pcTarget_d;
         illegal_q   <= illegal_d;
         sp_q        <= sp_d;
         depth_q     <= depth_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         dropped_q   <= dropped_d;
      end
   end

   // Stack contents need no reset; sp and depth alone define what is valid.
   always_ff @(negedge clk) begin
      if (pushEn)
         stack_q[sp_q] <= retAddr_q;
   end

   assign busy            = (state_q != S_IDLE);
   assign w_out           = w_q;
   assign status_z        = z_q;
   assign status_dc       = dc_q;
   assign status_c        = c_q;
   assign pc_load         = pcLoad_q;
   assign pc_target       = pcTarget_q;
   assign illegal_op      = illegal_q;
   assign stack_overflow  = overflow_q;
   assign stack_underflow = underflow_q;
   assign ir_dropped      = dropped_q;

endmodule
